// File: rtl/soc_readout_pkg.sv
// Shared readout definitions: scan FSM encoding and default widths.
// Imported by the scanner top and the delta calculator.
package soc_readout_pkg;

  localparam int NumSoCDef    = 5;
  localparam int AddrWidthDef = 5;
  localparam int DataWidthDef = 24;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    WAIT,
    CAPT,
    EMIT
  } scan_state_e;

endpackage

// File: rtl/soc_readout_scanner_delta.sv
// soc_delta_calc: combinational baseline/count/threshold -> delta, alarm.
// Ports: base, base_valid, rebase, count, threshold, alarm_in -> delta, load, alarm_out.
module soc_delta_calc
  import soc_readout_pkg::*;
#(
  parameter int DataWidth = DataWidthDef
) (
  input  logic [DataWidth-1:0] base,
  input  logic                 base_valid,
  input  logic                 rebase,
  input  logic [DataWidth-1:0] count,
  input  logic [DataWidth-1:0] threshold,
  input  logic                 alarm_in,
  output logic [DataWidth-1:0] delta,
  output logic                 load,
  output logic                 alarm_out
);

  always_comb begin
    load  = rebase | ~base_valid;
    delta = '0;
    // Only degradation counts; a count above the baseline saturates to 0.
    if (!load && (count <= base)) begin
      delta = base - count;
    end
    alarm_out = rebase ? 1'b0 : (alarm_in | (delta > threshold));
  end

endmodule

// File: rtl/soc_readout_scanner.sv
// Scans NumSoC SRAM counters, compares against stored baselines, emits results.
// Ports: clk/rstn, Start/Rebase/Threshold, SRAM Addr/Data, result handshake, Alarm/Busy/Done.
module soc_readout_scanner
  import soc_readout_pkg::*;
#(
  parameter int NumSoC    = NumSoCDef,
  parameter int AddrWidth = AddrWidthDef,
  parameter int DataWidth = DataWidthDef
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 Start_i,
  input  logic                 Rebase_i,
  input  logic [DataWidth-1:0] Threshold_i,
  output logic [AddrWidth-1:0] Addr_o,
  input  logic [DataWidth-1:0] Data_i,
  output logic                 ResValid_o,
  input  logic                 ResReady_i,
  output logic [AddrWidth-1:0] ResIdx_o,
  output logic [DataWidth-1:0] ResCount_o,
  output logic [DataWidth-1:0] ResDelta_o,
  output logic [NumSoC-1:0]    Alarm_o,
  output logic                 Busy_o,
  output logic                 Done_o
);

  localparam int IdxW = (NumSoC > 1) ? $clog2(NumSoC) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NumSoC - 1);

  scan_state_e          state_q;
  logic [IdxW-1:0]      idx_q;
  logic [IdxW-1:0]      idx_inc;
  logic                 rebase_q;
  logic [NumSoC-1:0]    bvalid_q;
  logic [DataWidth-1:0] base_q [NumSoC];

  logic [DataWidth-1:0] delta;
  logic                 load;
  logic                 alarm_nxt;

  assign idx_inc = idx_q + 1'b1;

  soc_delta_calc #(
    .DataWidth (DataWidth)
  ) u_delta (
    .base       (base_q[idx_q]),
    .base_valid (bvalid_q[idx_q]),
    .rebase     (rebase_q),
    .count      (Data_i),
    .threshold  (Threshold_i),
    .alarm_in   (Alarm_o[idx_q]),
    .delta      (delta),
    .load       (load),
    .alarm_out  (alarm_nxt)
  );

  // Baseline contents need no reset; the valid bits gate them.
  always_ff @(posedge clk) begin
    if (state_q == CAPT && load) begin
      base_q[idx_q] <= Data_i;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      rebase_q   <= 1'b0;
      bvalid_q   <= '0;
      Addr_o     <= '0;
      ResValid_o <= 1'b0;
      ResIdx_o   <= '0;
      ResCount_o <= '0;
      ResDelta_o <= '0;
      Alarm_o    <= '0;
      Busy_o     <= 1'b0;
      Done_o     <= 1'b0;
    end else begin
      Done_o <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (Start_i) begin
            rebase_q <= Rebase_i;
            idx_q    <= '0;
            Addr_o   <= '0;
            Busy_o   <= 1'b1;
            state_q  <= ADDR;
          end
        end
        ADDR: state_q <= WAIT;
        WAIT: state_q <= CAPT;
        CAPT: begin
          ResCount_o      <= Data_i;
          ResDelta_o      <= delta;
          ResIdx_o        <= AddrWidth'(idx_q);
          Alarm_o[idx_q]  <= alarm_nxt;
          bvalid_q[idx_q] <= 1'b1;
          ResValid_o      <= 1'b1;
          state_q         <= EMIT;
        end
        EMIT: begin
          if (ResReady_i) begin
            ResValid_o <= 1'b0;
            if (idx_q == LastIdx) begin
              Busy_o  <= 1'b0;
              Done_o  <= 1'b1;
              state_q <= IDLE;
            end else begin
              idx_q   <= idx_inc;
              Addr_o  <= AddrWidth'(idx_inc);
              state_q <= ADDR;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_soc_readout_scanner.sv
// Directed bench for soc_readout_scanner with a registered-read SRAM model.
// Table of scans plus backpressure, mid-scan reset and held-Start sequences.
module tb_soc_readout_scanner;

  typedef logic [4:0][23:0] dvec_t;

  typedef struct packed {
    logic        rb;
    logic [23:0] thr;
    dvec_t       data;
    dvec_t       exp_d;
    logic [4:0]  alarm;
  } scan_t;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        Start_i = 1'b0;
  logic        Rebase_i = 1'b0;
  logic [23:0] Threshold_i = '0;
  logic [4:0]  Addr_o;
  logic [23:0] Data_i = '0;
  logic        ResValid_o;
  logic        ResReady_i = 1'b1;
  logic [4:0]  ResIdx_o;
  logic [23:0] ResCount_o;
  logic [23:0] ResDelta_o;
  logic [4:0]  Alarm_o;
  logic        Busy_o;
  logic        Done_o;

  logic [23:0] mem [32];
  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  always @(posedge clk) Data_i <= mem[Addr_o];

  soc_readout_scanner dut (
    .clk         (clk),
    .rstn        (rstn),
    .Start_i     (Start_i),
    .Rebase_i    (Rebase_i),
    .Threshold_i (Threshold_i),
    .Addr_o      (Addr_o),
    .Data_i      (Data_i),
    .ResValid_o  (ResValid_o),
    .ResReady_i  (ResReady_i),
    .ResIdx_o    (ResIdx_o),
    .ResCount_o  (ResCount_o),
    .ResDelta_o  (ResDelta_o),
    .Alarm_o     (Alarm_o),
    .Busy_o      (Busy_o),
    .Done_o      (Done_o)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  function automatic dvec_t mk(input int a0, input int a1, input int a2,
                               input int a3, input int a4);
    dvec_t r;
    r[0] = 24'(a0);
    r[1] = 24'(a1);
    r[2] = 24'(a2);
    r[3] = 24'(a3);
    r[4] = 24'(a4);
    return r;
  endfunction

  task automatic run_scan(input string tag, input scan_t s,
                          input int stall_idx, input int stall_n,
                          input int exp_cyc);
    int cyc;
    int n;
    int held;
    bit seen;
    bit hold_bad;
    logic [4:0]  hi;
    logic [23:0] hc;
    logic [23:0] hd;
    for (int k = 0; k < 5; k++) mem[k] = s.data[k];
    Start_i = 1'b1;
    Rebase_i = s.rb;
    Threshold_i = s.thr;
    ResReady_i = 1'b1;
    @(posedge clk); #1;
    Start_i = 1'b0;
    Rebase_i = 1'b0;
    chk({tag, " busy_start"}, 32'(Busy_o), 1);
    cyc = 0; n = 0; held = 0; seen = 0; hold_bad = 0;
    hi = '0; hc = '0; hd = '0;
    while (cyc < 200 && !seen) begin
      if (Done_o) begin
        seen = 1;
      end else begin
        if (ResValid_o && int'(ResIdx_o) == stall_idx && held < stall_n) begin
          if (held == 0) begin
            hi = ResIdx_o; hc = ResCount_o; hd = ResDelta_o;
          end else if (ResIdx_o !== hi || ResCount_o !== hc ||
                       ResDelta_o !== hd) begin
            hold_bad = 1;
          end
          ResReady_i = 1'b0;
          held++;
        end else if (ResValid_o) begin
          ResReady_i = 1'b1;
          if (n < 5) begin
            chk($sformatf("%s idx%0d", tag, n), 32'(ResIdx_o), 32'(n));
            chk($sformatf("%s cnt%0d", tag, n), 32'(ResCount_o),
                32'(s.data[n]));
            chk($sformatf("%s dlt%0d", tag, n), 32'(ResDelta_o),
                32'(s.exp_d[n]));
          end
          n++;
        end else begin
          ResReady_i = 1'b1;
        end
        @(posedge clk); #1;
        cyc++;
      end
    end
    ResReady_i = 1'b1;
    chk({tag, " done_seen"}, 32'(seen), 1);
    chk({tag, " cycles"}, 32'(cyc), 32'(exp_cyc));
    chk({tag, " results"}, 32'(n), 5);
    chk({tag, " alarm"}, 32'(Alarm_o), 32'(s.alarm));
    chk({tag, " busy_done"}, 32'(Busy_o), 0);
    if (stall_n > 0) begin
      chk({tag, " stall_cnt"}, 32'(held), 32'(stall_n));
      chk({tag, " hold"}, 32'(hold_bad), 0);
    end
    @(posedge clk); #1;
    chk({tag, " done_pulse"}, 32'(Done_o), 0);
  endtask

  scan_t tbl [4];

  initial begin
    int dones;
    int last_done;
    int idx_exp;
    bit prev_done;
    bit seen;
    scan_t s;

    for (int k = 0; k < 32; k++) mem[k] = '0;

    tbl[0] = '{rb: 1'b0, thr: 24'd50,
               data: mk(1000, 2000, 3000, 4000, 5000),
               exp_d: mk(0, 0, 0, 0, 0), alarm: 5'b00000};
    tbl[1] = '{rb: 1'b0, thr: 24'd50,
               data: mk(990, 2000, 2900, 4100, 5000),
               exp_d: mk(10, 0, 100, 0, 0), alarm: 5'b00100};
    tbl[2] = '{rb: 1'b0, thr: 24'd50,
               data: mk(990, 2000, 2900, 4100, 5000),
               exp_d: mk(10, 0, 100, 0, 0), alarm: 5'b00100};
    tbl[3] = '{rb: 1'b1, thr: 24'd50,
               data: mk(990, 2000, 2900, 4100, 5000),
               exp_d: mk(0, 0, 0, 0, 0), alarm: 5'b00000};

    repeat (3) @(posedge clk);
    #1;
    chk("rst addr", 32'(Addr_o), 0);
    chk("rst valid", 32'(ResValid_o), 0);
    chk("rst busy", 32'(Busy_o), 0);
    chk("rst done", 32'(Done_o), 0);
    chk("rst alarm", 32'(Alarm_o), 0);
    rstn = 1'b1;
    @(posedge clk); #1;

    for (int t = 0; t < 4; t++) begin
      run_scan($sformatf("scan%0d", t), tbl[t], -1, 0, 20);
    end

    // Backpressure at index 2 for 7 cycles; baseline is post-rebase.
    s = '{rb: 1'b0, thr: 24'd50,
          data: mk(990, 2000, 2800, 4100, 5000),
          exp_d: mk(0, 0, 100, 0, 0), alarm: 5'b00100};
    run_scan("stall", s, 2, 7, 27);

    // Reset during WAIT of index 3.
    for (int k = 0; k < 5; k++) mem[k] = 24'(7 + k);
    Start_i = 1'b1;
    @(posedge clk); #1;
    Start_i = 1'b0;
    repeat (13) @(posedge clk);
    #1;
    chk("mid addr3", 32'(Addr_o), 3);
    chk("mid valid", 32'(ResValid_o), 0);
    rstn = 1'b0;
    #2;
    chk("mr addr", 32'(Addr_o), 0);
    chk("mr valid", 32'(ResValid_o), 0);
    chk("mr idx", 32'(ResIdx_o), 0);
    chk("mr count", 32'(ResCount_o), 0);
    chk("mr delta", 32'(ResDelta_o), 0);
    chk("mr alarm", 32'(Alarm_o), 0);
    chk("mr busy", 32'(Busy_o), 0);
    chk("mr done", 32'(Done_o), 0);
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    dones = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (Done_o) dones++;
    end
    chk("mr no_done", 32'(dones), 0);
    chk("mr idle", 32'(Busy_o), 0);
    s = '{rb: 1'b0, thr: 24'd0,
          data: mk(7, 8, 9, 10, 11),
          exp_d: mk(0, 0, 0, 0, 0), alarm: 5'b00000};
    run_scan("postrst", s, -1, 0, 20);

    // Start held high: scans chain through the Done cycle.
    Start_i = 1'b1;
    ResReady_i = 1'b1;
    dones = 0; last_done = -1; idx_exp = 0; prev_done = 0;
    for (int c = 0; c < 70; c++) begin
      @(posedge clk); #1;
      if (prev_done) chk("b2b rearm", 32'(Busy_o), 1);
      prev_done = Done_o;
      if (ResValid_o) begin
        chk("b2b idx", 32'(ResIdx_o), 32'(idx_exp));
        idx_exp = (idx_exp + 1) % 5;
      end
      if (Done_o) begin
        dones++;
        chk("b2b busy", 32'(Busy_o), 0);
        if (last_done >= 0) chk("b2b period", 32'(c - last_done), 21);
        last_done = c;
      end
    end
    chk("b2b dones", 32'(dones), 3);
    Start_i = 1'b0;
    seen = 0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(posedge clk); #1;
      if (Done_o) seen = 1;
    end
    chk("b2b final_done", 32'(seen), 1);
    @(posedge clk); #1;
    chk("b2b stop", 32'(Busy_o), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
